// File: rtl/seg_pkg.sv
// Shared seven-segment types: segment vector, blank pattern and hex glyph table.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    localparam seg_t HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment glyph.
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    always_comb begin
        seg = HEX_SEG[nibble];
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed hex display scanner with frame shadowing, leading-zero blanking,
// an inter-digit guard cycle and optional PWM dimming (macro SEG_BRIGHTNESS_EN).
module seven_seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] number,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    input  logic [3:0]              brightness,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    generate
        if (REFRESH_DIV < 32 || (REFRESH_DIV % 16) != 0) begin : g_bad_refresh_div
            $error("REFRESH_DIV must be a multiple of 16 and at least 32");
        end
        if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_num_digits
            $error("NUM_DIGITS must be in 1..16");
        end
    endgenerate

    logic [PRE_W-1:0]        prescaler;
    logic [IDX_W-1:0]        digit_idx;
    logic                    slot_start;
    logic                    slot_end;
    logic                    frame_start;

    logic [4*NUM_DIGITS-1:0] number_sh;
    logic [NUM_DIGITS-1:0]   dp_sh;
    logic                    blank_lz_sh;

    logic [4*NUM_DIGITS-1:0] number_eff;
    logic [NUM_DIGITS-1:0]   dp_eff;
    logic                    blank_lz_eff;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [3:0]              cur_nibble;
    seg_t                    cur_seg;
    logic                    lit;
    logic [NUM_DIGITS-1:0]   an_nxt;

    assign slot_start  = (prescaler == '0);
    assign slot_end    = (prescaler == PRE_MAX);
    assign frame_start = slot_start && (digit_idx == '0);
    assign frame_tick  = slot_end && (digit_idx == IDX_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            digit_idx <= '0;
        end else if (slot_end) begin
            prescaler <= '0;
            digit_idx <= (digit_idx == IDX_MAX) ? '0 : digit_idx + 1'b1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            number_sh   <= '0;
            dp_sh       <= '0;
            blank_lz_sh <= 1'b0;
        end else if (frame_start) begin
            number_sh   <= number;
            dp_sh       <= dp_in;
            blank_lz_sh <= blank_lz;
        end
    end

    // On the capture cycle the shadows are still stale, so the output registers
    // take the values being captured; digit 0 then shows one value for its whole slot.
    always_comb begin
        number_eff   = frame_start ? number   : number_sh;
        dp_eff       = frame_start ? dp_in    : dp_sh;
        blank_lz_eff = frame_start ? blank_lz : blank_lz_sh;
    end

    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        lz_blank   = '0;
        for (int unsigned k = NUM_DIGITS; k > 0; k--) begin
            zero_above    = zero_above && (number_eff[4*(k-1) +: 4] == 4'h0);
            lz_blank[k-1] = blank_lz_eff && zero_above && (k > 1);
        end
    end

    always_comb begin
        cur_nibble = number_eff[4*int'(digit_idx) +: 4];
    end

    seg_hex_decoder u_hex_decoder (
        .nibble (cur_nibble),
        .seg    (cur_seg)
    );

`ifdef SEG_BRIGHTNESS_EN
    localparam int SUB_LEN = REFRESH_DIV / 16;
    localparam int SUB_W   = $clog2(SUB_LEN);
    localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(SUB_LEN - 1);

    logic [SUB_W-1:0] sub_cnt;
    logic [3:0]       sub_idx;
    logic [3:0]       bright_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_cnt <= '0;
            sub_idx <= '0;
        end else if (slot_end) begin
            sub_cnt <= '0;
            sub_idx <= '0;
        end else if (sub_cnt == SUB_MAX) begin
            sub_cnt <= '0;
            sub_idx <= sub_idx + 1'b1;
        end else begin
            sub_cnt <= sub_cnt + 1'b1;
        end
    end

    // Loaded at prescaler 0; that cycle is the guard cycle, so the stale value is never used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bright_q <= '0;
        end else if (slot_start) begin
            bright_q <= brightness;
        end
    end

    assign lit = (sub_idx <= bright_q);
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign lit = 1'b1;
`endif

    always_comb begin
        an_nxt = '1;
        if (!slot_start && lit) begin
            an_nxt[digit_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an      <= '1;
            seg_out <= SEG_BLANK;
            dp_out  <= 1'b1;
        end else begin
            an      <= an_nxt;
            seg_out <= lz_blank[digit_idx] ? SEG_BLANK : cur_seg;
            dp_out  <= ~dp_eff[digit_idx];
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench for seven_seg_scan_driver (4 digits, 32 clocks per slot).
module tb_seven_seg_scan_driver;

    localparam int ND    = 4;
    localparam int RD    = 32;
    localparam int FRAME = ND * RD;
    localparam int ON_FULL = 31;
`ifdef SEG_BRIGHTNESS_EN
    localparam int ON_B3 = 7;
`else
    localparam int ON_B3 = 31;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] number = '0;
    logic [3:0]  dp_in = '0;
    logic        blank_lz = 1'b0;
    logic [3:0]  brightness = 4'hF;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  an;
    logic        frame_tick;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        int         on;
    } slot_t;

    slot_t exp_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    edges = 0;

    seven_seg_scan_driver #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .number     (number),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .brightness (brightness),
        .seg_out    (seg_out),
        .dp_out     (dp_out),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] a, input logic [6:0] s, input logic d, input int on);
        slot_t e;
        e.an = a; e.seg = s; e.dp = d; e.on = on;
        exp_q.push_back(e);
    endtask

    // Waits until just after release-relative edge k (edge 0 is the first after release).
    task automatic wait_edge(input int k);
        while (edges < k + 1) begin
            @(posedge clk);
            edges++;
        end
        #1;
    endtask

    task automatic start(input logic [15:0] n, input logic [3:0] d, input logic b, input logic [3:0] br);
        number = n; dp_in = d; blank_lz = b; brightness = br;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        edges = 0;
    endtask

    task automatic stop_after(input int k);
        wait_edge(k);
        @(negedge clk);
        #1 rst = 1'b1;
    endtask

    // Monitor: a slot is presented when a new anode goes low; its duty is
    // measured until the anode pattern changes again.
    slot_t      cur;
    int         on_cnt = 0;
    bit         counting = 0;
    logic [3:0] prev_an = 4'hF;
    int         gap = 0;
    bit         have_tick = 0;

    always @(negedge clk) begin
        if (rst) begin
            counting  = 0;
            have_tick = 0;
            prev_an   = 4'hF;
        end else begin
            gap++;
            if (frame_tick) begin
                if (have_tick) chk("frame_tick_period", gap, FRAME);
                have_tick = 1;
                gap = 0;
            end
            if (counting && an != prev_an) begin
                chk("slot_on_cycles", on_cnt, cur.on);
                counting = 0;
            end
            if (an != 4'hF && an != prev_an) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_slot_an", an, 4'hF);
                end else begin
                    cur = exp_q.pop_front();
                    chk("slot_an", an, cur.an);
                    chk("slot_seg", seg_out, cur.seg);
                    chk("slot_dp", dp_out, cur.dp);
                    counting = 1;
                    on_cnt = 0;
                end
            end
            if (counting) on_cnt++;
            prev_an = an;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_an", an, 4'hF);
        chk("reset_seg", seg_out, 7'h7F);
        chk("reset_dp", dp_out, 1);
        chk("reset_frame_tick", frame_tick, 0);

        // 1234, no blanking, full brightness, two frames
        for (int f = 0; f < 2; f++) begin
            push(4'b1110, 7'h19, 1'b1, ON_FULL);
            push(4'b1101, 7'h30, 1'b1, ON_FULL);
            push(4'b1011, 7'h24, 1'b1, ON_FULL);
            push(4'b0111, 7'h79, 1'b1, ON_FULL);
        end
        start(16'h1234, 4'b0000, 1'b0, 4'hF);
        wait_edge(0);
        chk("guard_first_cycle_an", an, 4'hF);
        wait_edge(125);
        chk("frame_tick_early", frame_tick, 0);
        wait_edge(126);
        chk("frame_tick_last_cycle", frame_tick, 1);
        wait_edge(127);
        chk("frame_tick_width", frame_tick, 0);
        stop_after(2 * FRAME);

        // 0050 with leading-zero blanking; dp on digits 0 and 2 (digit 2 blanked)
        push(4'b1110, 7'h40, 1'b0, ON_FULL);
        push(4'b1101, 7'h12, 1'b1, ON_FULL);
        push(4'b1011, 7'h7F, 1'b0, ON_FULL);
        push(4'b0111, 7'h7F, 1'b1, ON_FULL);
        start(16'h0050, 4'b0101, 1'b1, 4'hF);
        stop_after(FRAME);

        // all zero with blanking: only digit 0 lit
        push(4'b1110, 7'h40, 1'b1, ON_FULL);
        push(4'b1101, 7'h7F, 1'b1, ON_FULL);
        push(4'b1011, 7'h7F, 1'b1, ON_FULL);
        push(4'b0111, 7'h7F, 1'b1, ON_FULL);
        start(16'h0000, 4'b0000, 1'b1, 4'hF);
        stop_after(FRAME);

        // DEAD changed to BEEF inside slot 2: frame 0 stays DEAD
        push(4'b1110, 7'h21, 1'b1, ON_FULL);
        push(4'b1101, 7'h08, 1'b1, ON_FULL);
        push(4'b1011, 7'h06, 1'b1, ON_FULL);
        push(4'b0111, 7'h21, 1'b1, ON_FULL);
        push(4'b1110, 7'h0E, 1'b1, ON_FULL);
        push(4'b1101, 7'h06, 1'b1, ON_FULL);
        push(4'b1011, 7'h06, 1'b1, ON_FULL);
        push(4'b0111, 7'h03, 1'b1, ON_FULL);
        start(16'hDEAD, 4'b0000, 1'b0, 4'hF);
        wait_edge(70);
        number = 16'hBEEF;
        stop_after(2 * FRAME);

        // brightness 3
        push(4'b1110, 7'h19, 1'b1, ON_B3);
        push(4'b1101, 7'h30, 1'b1, ON_B3);
        push(4'b1011, 7'h24, 1'b1, ON_B3);
        push(4'b0111, 7'h79, 1'b1, ON_B3);
        start(16'h1234, 4'b0000, 1'b0, 4'h3);
        stop_after(FRAME);

        // reset asserted mid-slot 2, then restart with a new value
        push(4'b1110, 7'h19, 1'b1, ON_FULL);
        push(4'b1101, 7'h30, 1'b1, ON_FULL);
        push(4'b1011, 7'h24, 1'b1, ON_FULL);
        start(16'h1234, 4'b0000, 1'b0, 4'hF);
        wait_edge(74);
        rst = 1'b1;
        #1;
        chk("midreset_an", an, 4'hF);
        chk("midreset_seg", seg_out, 7'h7F);
        chk("midreset_dp", dp_out, 1);
        chk("midreset_frame_tick", frame_tick, 0);
        push(4'b1110, 7'h00, 1'b1, ON_FULL);
        push(4'b1101, 7'h78, 1'b1, ON_FULL);
        push(4'b1011, 7'h02, 1'b1, ON_FULL);
        push(4'b0111, 7'h12, 1'b1, ON_FULL);
        start(16'h5678, 4'b0000, 1'b0, 4'hF);
        stop_after(FRAME);

        repeat (2) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
